// File: rtl/dpll_pkg.sv
// dpll_pkg: state encoding, default timing constants and step-to-code mapping
// shared by the DPLL lock controller and its frequency meter.
package dpll_pkg;
   localparam int WIN_CYCLES_DEF    = 1024;
   localparam int SETTLE_CYCLES_DEF = 64;
   localparam int LOCK_TOL_DEF      = 2;
   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_HOLD} state_t;
   function automatic logic [7:0] k_to_code(input logic [3:0] k);
      return {k, 4'h1};
   endfunction
endpackage

// File: rtl/dpll_freq_meter.sv
// dpll_freq_meter: counts rising edges of registered dco_fb over a WIN_CYCLES window
// opened by go; done is high in the last window cycle so cnt is final on the next edge.
module dpll_freq_meter #(
   parameter int WIN_CYCLES = 1024,
   parameter int CNT_W      = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             go,
   input  logic             dco_fb,
   output logic             done,
   output logic [CNT_W-1:0] cnt
);
   localparam int TW = $clog2(WIN_CYCLES + 1);
   logic          fb_q, fb_d, active, rise;
   logic [TW-1:0] timer;
   assign rise = fb_q & ~fb_d;
   assign done = active && timer == TW'(WIN_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fb_q   <= 1'b0;
         fb_d   <= 1'b0;
         active <= 1'b0;
         timer  <= '0;
         cnt    <= '0;
      end else begin
         fb_q <= dco_fb;
         fb_d <= fb_q;
         if (clr) begin
            active <= 1'b0;
            timer  <= '0;
            cnt    <= '0;
         end else if (go) begin
            active <= 1'b1;
            timer  <= '0;
            cnt    <= '0;
         end else if (active) begin
            active <= !done;
            timer  <= timer + 1'b1;
            if (rise && !(&cnt)) cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/dpll_lock_ctrl.sv
// dpll_lock_ctrl: DCO frequency acquisition by 4-bit SAR, then bang-bang tracking with lock detect.
// DPLL_LOCK_CTRL_TRACK_EN enables continuous tracking; otherwise one verdict window, then HOLD.
module dpll_lock_ctrl
   import dpll_pkg::*;
#(
   parameter int WIN_CYCLES    = WIN_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int CNT_W         = 12,
   parameter int LOCK_TOL      = LOCK_TOL_DEF,
   parameter int LOCK_CNT      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] target_cnt,
   input  logic             dco_fb,
   output logic             dco_en,
   output logic [7:0]       dco_code,
   output logic             busy,
   output logic             locked
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int EW = CNT_W + 1;
   localparam logic signed [CNT_W:0] TOL  = EW'(LOCK_TOL);
   localparam logic signed [CNT_W:0] NTOL = -TOL;
   state_t             state, state_n;
   logic [3:0]         k, k_n;
   logic [1:0]         b, b_n;
   logic               trk, trk_n, locked_n, en_n, go, done, in_tol;
   logic [CNT_W-1:0]   tgt, tgt_n, cnt;
   logic [GW-1:0]      good, good_n, good_inc;
   logic [SW-1:0]      scnt, scnt_n;
   logic signed [CNT_W:0] err;
   dpll_freq_meter #(.WIN_CYCLES(WIN_CYCLES), .CNT_W(CNT_W)) u_meter (
      .clk(clk), .rst_n(rst_n), .clr(stop), .go(go), .dco_fb(dco_fb), .done(done), .cnt(cnt)
   );
   assign busy     = state != S_IDLE;
   assign dco_code = k_to_code(k);
   always_comb begin
      state_n  = state;
      k_n      = k;
      b_n      = b;
      trk_n    = trk;
      tgt_n    = tgt;
      good_n   = good;
      locked_n = locked;
      en_n     = dco_en;
      scnt_n   = scnt;
      go       = 1'b0;
      err      = $signed({1'b0, cnt}) - $signed({1'b0, tgt});
      in_tol   = err <= TOL && err >= NTOL;
      good_inc = (good == GW'(LOCK_CNT)) ? good : good + 1'b1;
      case (state)
         S_IDLE: if (start) begin
            tgt_n   = target_cnt;
            k_n     = 4'd8;
            b_n     = 2'd3;
            trk_n   = 1'b0;
            en_n    = 1'b1;
            state_n = S_SETTLE;
         end
         S_SETTLE: begin
            scnt_n = scnt + 1'b1;
            if (scnt == SW'(SETTLE_CYCLES - 1)) begin
               scnt_n  = '0;
               go      = 1'b1;
               state_n = S_MEASURE;
            end
         end
         S_MEASURE: if (done) state_n = S_DECIDE;
         S_DECIDE: begin
            state_n = S_SETTLE;
            if (!trk) begin
               k_n = (cnt < tgt) ? k & ~(4'b1 << b) : k;
               if (b != 2'd0) begin
                  k_n = k_n | (4'b1 << (b - 2'd1));
                  b_n = b - 2'd1;
               end else trk_n = 1'b1;
            end else begin
               good_n = in_tol ? good_inc : '0;
`ifdef DPLL_LOCK_CTRL_TRACK_EN
               locked_n = in_tol && good_inc == GW'(LOCK_CNT);
               k_n      = in_tol ? k : (err > TOL) ? ((&k) ? k : k + 4'd1) : ((k == 4'd0) ? k : k - 4'd1);
`else
               locked_n = in_tol;
               state_n  = S_HOLD;
`endif
            end
         end
         default: ;
      endcase
      // stop overrides everything, including a start in the same cycle
      if (stop) begin
         state_n  = S_IDLE;
         k_n      = 4'd8;
         b_n      = 2'd3;
         trk_n    = 1'b0;
         good_n   = '0;
         locked_n = 1'b0;
         en_n     = 1'b0;
         scnt_n   = '0;
         go       = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         k      <= 4'd8;
         b      <= 2'd3;
         trk    <= 1'b0;
         tgt    <= '0;
         good   <= '0;
         locked <= 1'b0;
         dco_en <= 1'b0;
         scnt   <= '0;
      end else begin
         state  <= state_n;
         k      <= k_n;
         b      <= b_n;
         trk    <= trk_n;
         tgt    <= tgt_n;
         good   <= good_n;
         locked <= locked_n;
         dco_en <= en_n;
         scnt   <= scnt_n;
      end
   end
endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// tb_dpll_lock_ctrl: scoreboard bench with a DCO model giving N = 200 + off - 10*k edges per window.
`timescale 1ns/1ps
module tb_dpll_lock_ctrl;
   localparam int S = 64;
   localparam int W = 1024;
   localparam int P = S + W + 1;
   typedef struct {
      logic [7:0] code;
      logic       lk;
   } exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, dco_fb = 1'b0;
   logic [11:0] target_cnt = '0;
   logic        dco_en, busy, locked;
   logic [7:0]  dco_code;
   logic [7:0]  last_code = 8'h81;
   int          passed = 0, total = 0;
   int          off = 0, n_k = 8, cd = 0, acc = 0, n;
   exp_t        exp_q[$];
   always #5 clk = ~clk;
   dpll_lock_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .target_cnt(target_cnt),
      .dco_fb(dco_fb), .dco_en(dco_en), .dco_code(dco_code), .busy(busy), .locked(locked)
   );
   assign n = 200 + off - 10 * n_k;
   // rate follows the code a few cycles before the window opens, covering the feedback pipeline
   always @(posedge clk) begin
      if (dco_code != last_code) begin
         last_code <= dco_code;
         cd        <= S - 8;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) n_k <= int'(dco_code[7:4]);
      end
      if (!dco_en) begin
         acc    <= 0;
         dco_fb <= 1'b0;
      end else if (acc + n >= W) begin
         acc    <= acc + n - W;
         dco_fb <= 1'b1;
      end else begin
         acc    <= acc + n;
         dco_fb <= 1'b0;
      end
   end
   task automatic pulse_start(input logic [11:0] t);
      @(negedge clk);
      target_cnt = t;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic pulse_stop();
      @(negedge clk);
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
   endtask
   task automatic push(input logic [7:0] c, input logic l);
      exp_t e;
      e.code = c;
      e.lk   = l;
      exp_q.push_back(e);
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (dco_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", dco_en); else passed++;
      total++; if (dco_code !== 8'h81) $display("FAIL reset_code got=%h exp=81", dco_code); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else passed++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask
   task automatic test_nominal();
      exp_t e;
      int   i = 0;
      pulse_start(12'd120);
      total++; if (busy !== 1'b1) $display("FAIL nominal_busy got=%b exp=1", busy); else passed++;
      total++; if (dco_en !== 1'b1) $display("FAIL nominal_en got=%b exp=1", dco_en); else passed++;
      total++; if (dco_code !== 8'h81) $display("FAIL nominal_first_trial got=%h exp=81", dco_code); else passed++;
      push(8'hC1, 0); push(8'hA1, 0); push(8'h91, 0); push(8'h81, 0);
`ifdef DPLL_LOCK_CTRL_TRACK_EN
      push(8'h81, 0); push(8'h81, 0); push(8'h81, 0); push(8'h81, 1);
`else
      push(8'h81, 1);
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (P) @(posedge clk);
         #1 i++;
         total++;
         if (dco_code !== e.code || locked !== e.lk)
            $display("FAIL nominal_decide%0d got code=%h locked=%b exp code=%h locked=%b", i, dco_code, locked, e.code, e.lk);
         else passed++;
      end
   endtask
   task automatic test_drift();
      exp_t e;
      int   i = 0;
      off = 10;
`ifdef DPLL_LOCK_CTRL_TRACK_EN
      push(8'h91, 0); push(8'h91, 0); push(8'h91, 0); push(8'h91, 0); push(8'h91, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (P) @(posedge clk);
         #1 i++;
         total++;
         if (dco_code !== e.code || locked !== e.lk)
            $display("FAIL drift_decide%0d got code=%h locked=%b exp code=%h locked=%b", i, dco_code, locked, e.code, e.lk);
         else passed++;
      end
`else
      repeat (3 * P) @(posedge clk);
      #1;
      total++; if (dco_code !== 8'h81) $display("FAIL hold_code got=%h exp=81", dco_code); else passed++;
      total++; if (locked !== 1'b1) $display("FAIL hold_locked got=%b exp=1", locked); else passed++;
      total++; if (busy !== 1'b1 || dco_en !== 1'b1) $display("FAIL hold_busy_en got=%b%b exp=11", busy, dco_en); else passed++;
`endif
      pulse_stop();
      off = 0;
      total++; if (busy !== 1'b0) $display("FAIL stop_busy got=%b exp=0", busy); else passed++;
      total++; if (dco_en !== 1'b0) $display("FAIL stop_en got=%b exp=0", dco_en); else passed++;
      total++; if (dco_code !== 8'h81) $display("FAIL stop_code got=%h exp=81", dco_code); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL stop_locked got=%b exp=0", locked); else passed++;
   endtask
   task automatic test_range();
      exp_t e;
      int   i = 0;
      pulse_start(12'd205);
      push(8'h41, 0); push(8'h21, 0); push(8'h11, 0); push(8'h01, 0);
`ifdef DPLL_LOCK_CTRL_TRACK_EN
      push(8'h01, 0); push(8'h01, 0); push(8'h01, 0); push(8'h01, 0);
`else
      push(8'h01, 0);
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (P) @(posedge clk);
         #1 i++;
         total++;
         if (dco_code !== e.code || locked !== e.lk)
            $display("FAIL range_decide%0d got code=%h locked=%b exp code=%h locked=%b", i, dco_code, locked, e.code, e.lk);
         else passed++;
      end
      total++; if (busy !== 1'b1) $display("FAIL range_busy got=%b exp=1", busy); else passed++;
      pulse_stop();
   endtask
   task automatic test_rst_mid();
      exp_t e;
      int   i = 0;
      pulse_start(12'd120);
      repeat (P + S + W / 2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if (dco_en !== 1'b0) $display("FAIL rstmid_en got=%b exp=0", dco_en); else passed++;
      total++; if (dco_code !== 8'h81) $display("FAIL rstmid_code got=%h exp=81", dco_code); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL rstmid_locked got=%b exp=0", locked); else passed++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      pulse_start(12'd120);
      push(8'hC1, 0); push(8'hA1, 0); push(8'h91, 0); push(8'h81, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (P) @(posedge clk);
         #1 i++;
         total++;
         if (dco_code !== e.code || locked !== e.lk)
            $display("FAIL rstmid_decide%0d got code=%h locked=%b exp code=%h locked=%b", i, dco_code, locked, e.code, e.lk);
         else passed++;
      end
      pulse_stop();
   endtask
   task automatic test_back_to_back();
      exp_t e;
      int   i = 0;
      pulse_start(12'd120);
      fork
         begin
            repeat (P + 10) @(negedge clk);
            start = 1'b1; target_cnt = 12'd205;
            @(negedge clk);
            start = 1'b0; target_cnt = 12'd120;
            repeat (P + 500) @(negedge clk);
            start = 1'b1; target_cnt = 12'd205;
            @(negedge clk);
            start = 1'b0; target_cnt = 12'd120;
         end
      join_none
      push(8'hC1, 0); push(8'hA1, 0); push(8'h91, 0); push(8'h81, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (P) @(posedge clk);
         #1 i++;
         total++;
         if (dco_code !== e.code || locked !== e.lk)
            $display("FAIL restart_decide%0d got code=%h locked=%b exp code=%h locked=%b", i, dco_code, locked, e.code, e.lk);
         else passed++;
      end
      pulse_stop();
      @(negedge clk);
      stop = 1'b1; start = 1'b1; target_cnt = 12'd120;
      @(posedge clk);
      #1 stop = 1'b0; start = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL stopstart_busy got=%b exp=0", busy); else passed++;
      total++; if (dco_en !== 1'b0) $display("FAIL stopstart_en got=%b exp=0", dco_en); else passed++;
      repeat (S + 20) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0 || dco_code !== 8'h81) $display("FAIL stopstart_idle got busy=%b code=%h exp busy=0 code=81", busy, dco_code); else passed++;
   endtask
   initial begin
      test_reset();
      test_nominal();
      test_drift();
      test_range();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
